// File: rtl/program_loader.sv
// program_loader
//   Boot-time loader placed in front of top_cpu. It receives a framed byte
//   stream (length L, L data bytes, checksum C = sum of data mod 256) over a
//   valid/ready handshake and writes the data bytes into the byte-wide
//   instruction memory from address 0. The CPU is held in reset until a
//   frame with a matching checksum has been fully written.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous active-low reset
//   rx_valid   : upstream byte valid
//   rx_data    : upstream byte
//   rx_ready   : loader can accept a byte (combinational from state/reset)
//   restart    : request a new load, honoured only in RUN or ERR
//   mem_we     : registered instruction-memory write strobe
//   mem_addr   : registered write address
//   mem_wdata  : registered write data
//   cpu_hold   : active-high reset for top_cpu
//   load_done  : good program loaded, CPU running
//   load_err   : frame rejected, CPU held
//   byte_count : data bytes accepted in the current frame
module program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-1:0] byte_count
);

  typedef enum logic [2:0] {
    WAIT_LEN = 3'd0,
    LOAD     = 3'd1,
    CHECK    = 3'd2,
    RUN      = 3'd3,
    ERR      = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [7:0]        len_reg, len_next;
  logic [7:0]        sum_reg, sum_next;
  logic [ADDR_W-1:0] byte_count_reg, byte_count_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [7:0]        mem_wdata_reg, mem_wdata_next;
  logic              cpu_hold_reg, cpu_hold_next;
  logic              load_done_reg, load_done_next;
  logic              load_err_reg, load_err_next;

  logic              transfer;
  logic [ADDR_W-1:0] byte_count_inc;
  logic [ADDR_W-1:0] len_ext;

  // Ready is forced low while reset is asserted so no byte is consumed then.
  assign rx_ready = reset && (state_reg == WAIT_LEN || state_reg == LOAD ||
                              state_reg == CHECK);
  assign transfer = rx_valid && rx_ready;

  // Within a frame the write address always equals the number of data bytes
  // already accepted, so byte_count doubles as the write address.
  assign byte_count_inc = byte_count_reg + ADDR_W'(1);
  assign len_ext        = ADDR_W'(len_reg);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= WAIT_LEN;
      len_reg        <= '0;
      sum_reg        <= '0;
      byte_count_reg <= '0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      cpu_hold_reg   <= 1'b1;
      load_done_reg  <= 1'b0;
      load_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      len_reg        <= len_next;
      sum_reg        <= sum_next;
      byte_count_reg <= byte_count_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      cpu_hold_reg   <= cpu_hold_next;
      load_done_reg  <= load_done_next;
      load_err_reg   <= load_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    len_next        = len_reg;
    sum_next        = sum_reg;
    byte_count_next = byte_count_reg;
    mem_we_next     = 1'b0;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    cpu_hold_next   = cpu_hold_reg;
    load_done_next  = load_done_reg;
    load_err_next   = load_err_reg;

    case (state_reg)
      WAIT_LEN: begin
        if (transfer) begin
          // Instructions are two bytes, so empty or odd lengths are invalid.
          if (rx_data == 8'd0 || rx_data[0]) begin
            state_next    = ERR;
            load_err_next = 1'b1;
          end else begin
            len_next        = rx_data;
            sum_next        = '0;
            byte_count_next = '0;
            state_next      = LOAD;
          end
        end
      end
      LOAD: begin
        if (transfer) begin
          mem_we_next     = 1'b1;
          mem_addr_next   = byte_count_reg;
          mem_wdata_next  = rx_data;
          byte_count_next = byte_count_inc;
          sum_next        = sum_reg + rx_data;
          if (byte_count_inc == len_ext) begin
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        // The last data write is already registered when C arrives, so it
        // commits no later than the edge that releases the CPU.
        if (transfer) begin
          if (rx_data == sum_reg) begin
            state_next     = RUN;
            cpu_hold_next  = 1'b0;
            load_done_next = 1'b1;
          end else begin
            state_next    = ERR;
            load_err_next = 1'b1;
          end
        end
      end
      RUN, ERR: begin
        if (restart) begin
          state_next      = WAIT_LEN;
          cpu_hold_next   = 1'b1;
          load_done_next  = 1'b0;
          load_err_next   = 1'b0;
          byte_count_next = '0;
        end
      end
      default: begin
        state_next = WAIT_LEN;
      end
    endcase
  end

  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign cpu_hold   = cpu_hold_reg;
  assign load_done  = load_done_reg;
  assign load_err   = load_err_reg;
  assign byte_count = byte_count_reg;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Directed, table-driven bench for program_loader. Each table record gives
//   the inputs for one clock cycle, the expected rx_ready before the edge and
//   the expected registered outputs after it. Reset mid-load is a hand
//   sequence after the table. A write-capture memory checks final contents.
module tb_program_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              restart;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W-1:0] byte_count;

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .restart   (restart),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // Captures what the loader actually writes.
  logic [7:0] mem_model [0:255];
  always @(posedge clk) begin
    if (mem_we) mem_model[mem_addr] <= mem_wdata;
  end

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rs;
    logic       rdy;
    logic       we;
    logic [7:0] a;
    logic [7:0] wd;
    logic       hold;
    logic       done;
    logic       err;
    logic [7:0] bc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] good [0:7];

  function automatic void add(input logic v, input logic [7:0] d, input logic rs,
                              input logic rdy, input logic we, input logic [7:0] a,
                              input logic [7:0] wd, input logic hold, input logic done,
                              input logic err, input logic [7:0] bc);
    vec_t t;
    t.v = v; t.d = d; t.rs = rs; t.rdy = rdy; t.we = we; t.a = a; t.wd = wd;
    t.hold = hold; t.done = done; t.err = err; t.bc = bc;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; rx_ready is sampled
  // before the next edge, registered outputs 1 unit after it.
  task automatic apply(input vec_t t, input string tag);
    rx_valid = t.v;
    rx_data  = t.d;
    restart  = t.rs;
    #1;
    chk({tag, " rx_ready"}, rx_ready, t.rdy);
    @(posedge clk);
    #1;
    chk({tag, " mem_we"}, mem_we, t.we);
    if (t.we) begin
      chk({tag, " mem_addr"}, mem_addr, t.a);
      chk({tag, " mem_wdata"}, mem_wdata, t.wd);
    end
    chk({tag, " cpu_hold"}, cpu_hold, t.hold);
    chk({tag, " load_done"}, load_done, t.done);
    chk({tag, " load_err"}, load_err, t.err);
    chk({tag, " byte_count"}, byte_count, t.bc);
    $display("vec %s v=%0b d=%02h rs=%0b -> we=%0b a=%0d wd=%02h hold=%0b done=%0b err=%0b bc=%0d",
             tag, t.v, t.d, t.rs, mem_we, mem_addr, mem_wdata, cpu_hold, load_done,
             load_err, byte_count);
  endtask

  // Appends a complete good frame (no gaps) that ends in RUN.
  function automatic void add_good_frame();
    add(1, good[0], 0, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      add(1, good[i+1], 0, 1, 1, 8'(i), good[i+1], 1, 0, 0, 8'(i+1));
    add(1, good[7], 0, 1, 0, 0, 0, 0, 1, 0, 6);
  endfunction

  initial begin
    good[0] = 8'h06; good[1] = 8'h84; good[2] = 8'h0A; good[3] = 8'h88;
    good[4] = 8'h14; good[5] = 8'h0D; good[6] = 8'h28; good[7] = 8'h5F;

    // Good frame, then rx_valid in RUN is ignored, then restart.
    add_good_frame();
    add(1, 8'h33, 0, 0, 0, 0, 0, 0, 1, 0, 6);
    add(0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0, 0);

    // Bad checksum 60: writes happen, ERR, later bytes ignored.
    add(1, good[0], 0, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      add(1, good[i+1], 0, 1, 1, 8'(i), good[i+1], 1, 0, 0, 8'(i+1));
    add(1, 8'h60, 0, 1, 0, 0, 0, 1, 0, 1, 6);
    add(1, 8'h11, 0, 0, 0, 0, 0, 1, 0, 1, 6);
    add(0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0, 0);

    // Illegal lengths 05 and 00.
    add(1, 8'h05, 0, 1, 0, 0, 0, 1, 0, 1, 0);
    add(1, 8'h02, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h00, 0, 1, 0, 0, 0, 1, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0, 0);

    // Backpressure: rx_valid low before every byte.
    add(0, 8'hEE, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    add(1, good[0], 0, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      add(0, 8'hEE, 0, 1, 0, 0, 0, 1, 0, 0, 8'(i));
      add(1, good[i+1], 0, 1, 1, 8'(i), good[i+1], 1, 0, 0, 8'(i+1));
    end
    add(0, 8'hEE, 0, 1, 0, 0, 0, 1, 0, 0, 6);
    add(1, good[7], 0, 1, 0, 0, 0, 0, 1, 0, 6);
    add(1, 8'hAA, 0, 0, 0, 0, 0, 0, 1, 0, 6);
    add(1, 8'hAB, 0, 0, 0, 0, 0, 0, 1, 0, 6);

    // Restart after a good load; restart in WAIT_LEN and LOAD is ignored.
    add(0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h02, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'hAA, 1, 1, 1, 0, 8'hAA, 1, 0, 0, 1);
    add(1, 8'h55, 1, 1, 1, 1, 8'h55, 1, 0, 0, 2);
    add(1, 8'hFF, 0, 1, 0, 0, 0, 0, 1, 0, 2);

    // Reset state.
    reset = 1'b0; rx_valid = 1'b1; rx_data = 8'h06; restart = 1'b0;
    @(posedge clk); #1;
    chk("reset rx_ready", rx_ready, 1'b0);
    @(posedge clk); #1;
    chk("reset mem_we", mem_we, 1'b0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset cpu_hold", cpu_hold, 1'b1);
    chk("reset load_done", load_done, 1'b0);
    chk("reset load_err", load_err, 1'b0);
    chk("reset byte_count", byte_count, 0);
    reset = 1'b1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("t%0d", i));

    chk("mem0 after restart frame", mem_model[0], 8'hAA);
    chk("mem1 after restart frame", mem_model[1], 8'h55);
    chk("mem2 untouched", mem_model[2], 8'h88);
    chk("mem5 untouched", mem_model[5], 8'h28);

    // Reset mid-load after three data bytes.
    vecs.delete();
    add(0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h06, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    add(1, 8'h11, 0, 1, 1, 0, 8'h11, 1, 0, 0, 1);
    add(1, 8'h22, 0, 1, 1, 1, 8'h22, 1, 0, 0, 2);
    add(1, 8'h33, 0, 1, 1, 2, 8'h33, 1, 0, 0, 3);
    foreach (vecs[i]) apply(vecs[i], $sformatf("r%0d", i));

    reset = 1'b0; rx_valid = 1'b1; rx_data = 8'h44;
    #1;
    chk("midreset rx_ready", rx_ready, 1'b0);
    @(posedge clk); #1;
    chk("midreset byte_count", byte_count, 0);
    chk("midreset cpu_hold", cpu_hold, 1'b1);
    chk("midreset mem_we", mem_we, 1'b0);
    chk("midreset load_done", load_done, 1'b0);
    $display("vec midreset -> bc=%0d hold=%0b we=%0b", byte_count, cpu_hold, mem_we);
    reset = 1'b1;

    vecs.delete();
    add_good_frame();
    foreach (vecs[i]) apply(vecs[i], $sformatf("g%0d", i));
    for (int i = 0; i < 6; i++)
      chk($sformatf("mem%0d final", i), mem_model[i], good[i+1]);

    rx_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
